// File: rtl/spi_pkg.sv
// spi_pkg -- shared definitions for the SPI master transmitter and receiver.
//   SPI_BITS / SPI_DIV : default word length and sck half-period (clk cycles)
//   spi_state_e        : transmitter FSM states
//   ph_width()         : phase-counter width for a given half-period
package spi_pkg;

    localparam int SPI_BITS = 32;
    localparam int SPI_DIV  = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        TRAIL
    } spi_state_e;

    // One extra bit over $clog2 keeps DIV=1 (a zero-width count) legal.
    function automatic int ph_width(input int div);
        return $clog2(div) + 1;
    endfunction

endpackage

// File: rtl/spi_master_out_if.sv
// spi_master_out_if -- request/serial bundle of the SPI master transmitter.
//   start, data_in              : request side (driven by the user)
//   busy, done, cs, sck, mosi   : status and serial lines (driven by the master)
// Modports: master = the transmitter, slave = the user/driver side.
interface spi_master_out_if
    import spi_pkg::*;
#(
    parameter int BITS = SPI_BITS
) ();

    logic            start;
    logic [BITS-1:0] data_in;
    logic            busy;
    logic            done;
    logic            cs;
    logic            sck;
    logic            mosi;

    modport master (
        input  start, data_in,
        output busy, done, cs, sck, mosi
    );

    modport slave (
        output start, data_in,
        input  busy, done, cs, sck, mosi
    );

endinterface

// File: rtl/spi_phase_timer.sv
// spi_phase_timer -- down-counter that times one FSM phase.
//   clk, reset : clock, async active-high reset
//   load       : reload DIV-1 (asserted on every state transition)
//   tick       : count has reached zero, i.e. the phase's last cycle
module spi_phase_timer
    import spi_pkg::*;
#(
    parameter int DIV = SPI_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic tick
);

    localparam int CW = ph_width(DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(DIV - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/spi_master_out.sv
// spi_master_out -- SPI master transmitter, MSB first, sck idle low,
// data launched on sck rising edge and sampled downstream on the falling edge.
//   clk, reset : clock, async active-high reset
//   bus        : spi_master_out_if.master (start/data_in in; busy/done/cs/sck/mosi out)
// Parameters: BITS word length, DIV clk cycles per sck half-period (>= 1).
// Build option: SPI_MOSI_INVERT_EN -- mosi carries the inverted data bit while
// cs is low (idle mosi stays 0 either way).
module spi_master_out
    import spi_pkg::*;
#(
    parameter int BITS = SPI_BITS,
    parameter int DIV  = SPI_DIV
) (
    input  logic              clk,
    input  logic              reset,
    spi_master_out_if.master  bus
);

`ifdef SPI_MOSI_INVERT_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    localparam int BW = (BITS > 1) ? $clog2(BITS) : 1;

    spi_state_e      state;
    logic [BITS-1:0] shreg;
    logic [BW-1:0]   bit_cnt;
    logic            tick;
    logic            load;

    // Timer restarts whenever the FSM changes state: on accepted start in
    // IDLE, and at every phase end otherwise (each phase ends in a transition).
    always_comb begin
        load = (state == IDLE) ? bus.start : tick;
    end

    spi_phase_timer #(.DIV(DIV)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            bus.cs   <= 1'b1;
            bus.sck  <= 1'b0;
            bus.mosi <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg    <= bus.data_in;
                        bit_cnt  <= BW'(BITS - 1);
                        bus.cs   <= 1'b0;
                        bus.busy <= 1'b1;
                        bus.mosi <= bus.data_in[BITS-1] ^ INV;
                        state    <= LEAD;
                    end
                end
                LEAD: begin
                    if (tick) begin
                        bus.sck <= 1'b1;
                        state   <= HIGH;
                    end
                end
                HIGH: begin
                    if (tick) begin
                        bus.sck <= 1'b0;
                        state   <= LOW;
                    end
                end
                LOW: begin
                    if (tick) begin
                        if (bit_cnt != '0) begin
                            // Next bit sits just below the MSB before the shift.
                            shreg    <= shreg << 1;
                            bit_cnt  <= bit_cnt - BW'(1);
                            bus.mosi <= shreg[BITS-2] ^ INV;
                            bus.sck  <= 1'b1;
                            state    <= HIGH;
                        end else begin
                            state <= TRAIL;
                        end
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        bus.cs   <= 1'b1;
                        bus.busy <= 1'b0;
                        bus.mosi <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_out.sv
// tb_spi_master_out -- directed bench for spi_master_out.
// Three DUTs: d0 BITS=8 DIV=2, d1 BITS=8 DIV=1, d2 BITS=32 DIV=3.
// A cycle-count model predicts {cs,sck,mosi,busy,done} for every cycle of
// every DUT; a serial monitor (receiver that stores !mosi) gives word-level
// results that are pinned with hand-computed constants.
module tb_spi_master_out;

`ifdef SPI_MOSI_INVERT_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic        clk;
    logic        rst     [3];
    logic        start_v [3];
    logic [31:0] data_v  [3];
    wire  [4:0]  act     [3];

    int checks   = 0;
    int failures = 0;

    spi_master_out_if #(.BITS(8))  bus0 ();
    spi_master_out_if #(.BITS(8))  bus1 ();
    spi_master_out_if #(.BITS(32)) bus2 ();

    spi_master_out #(.BITS(8),  .DIV(2)) dut0 (.clk(clk), .reset(rst[0]), .bus(bus0));
    spi_master_out #(.BITS(8),  .DIV(1)) dut1 (.clk(clk), .reset(rst[1]), .bus(bus1));
    spi_master_out #(.BITS(32), .DIV(3)) dut2 (.clk(clk), .reset(rst[2]), .bus(bus2));

    assign bus0.start   = start_v[0];
    assign bus0.data_in = data_v[0][7:0];
    assign bus1.start   = start_v[1];
    assign bus1.data_in = data_v[1][7:0];
    assign bus2.start   = start_v[2];
    assign bus2.data_in = data_v[2];

    assign act[0] = {bus0.cs, bus0.sck, bus0.mosi, bus0.busy, bus0.done};
    assign act[1] = {bus1.cs, bus1.sck, bus1.mosi, bus1.busy, bus1.done};
    assign act[2] = {bus2.cs, bus2.sck, bus2.mosi, bus2.busy, bus2.done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bp(input int d);
        return (d == 2) ? 32 : 8;
    endfunction

    function automatic int dp(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 3);
    endfunction

    // Expected outputs kk cycles after an accepted start (kk=0: idle).
    // Transaction = DIV lead + BITS sck periods + DIV trail, then a done cycle.
    function automatic logic [4:0] exp_out(input int b, input int dv, input int kk,
                                           input logic [31:0] w);
        int   len;
        int   t;
        int   j;
        logic s;
        len = (2 + 2 * b) * dv;
        if (kk == 0)       return 5'b10000;
        if (kk == len + 1) return 5'b10001;
        t = kk - 1;
        s = (t >= dv) && (t < dv + 2 * b * dv) && (((t - dv) % (2 * dv)) < dv);
        j = (t < dv) ? 0 : (t - dv) / (2 * dv);
        if (j > b - 1) j = b - 1;
        return {1'b0, s, w[b-1-j] ^ INV, 1'b1, 1'b0};
    endfunction

    // Model state: cycles since accepted start, and the word in flight.
    int          k    [3] = '{0, 0, 0};
    logic [31:0] word [3];

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            int len;
            len = (2 + 2 * bp(d)) * dp(d);
            if (rst[d]) begin
                k[d] = 0;
            end else if (k[d] == 0 || k[d] == len + 1) begin
                if (start_v[d]) begin
                    k[d]    = 1;
                    word[d] = data_v[d];
                end else begin
                    k[d] = 0;
                end
            end else begin
                k[d] = k[d] + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, a, e);
        end
    endtask

    // Serial monitor / receiver state.
    int          fall_c [3];
    int          rise_c [3];
    int          csl_c  [3];
    int          done_c [3];
    int          hi_run [3];
    int          gmin   [3];
    int          gmax   [3];
    logic        seen_lo[3];
    logic        prev_sck[3] = '{1'b0, 1'b0, 1'b0};
    logic [31:0] raw    [3];

    task automatic clr(input int d);
        fall_c[d]  = 0;
        rise_c[d]  = 0;
        csl_c[d]   = 0;
        done_c[d]  = 0;
        hi_run[d]  = 0;
        gmin[d]    = 999;
        gmax[d]    = 0;
        seen_lo[d] = 1'b0;
        raw[d]     = '0;
    endtask

    // Compare process plus monitor, away from the active edge.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            logic [4:0] e;
            e = rst[d] ? 5'b10000 : exp_out(bp(d), dp(d), k[d], word[d]);
            checks++;
            if (act[d] !== e) begin
                failures++;
                $display("FAIL cycle_d%0d k=%0d actual=%b required=%b (cs,sck,mosi,busy,done)",
                         d, k[d], act[d], e);
            end
            if (!act[d][4]) csl_c[d]++;
            if (act[d][0])  done_c[d]++;
            if (prev_sck[d] && !act[d][3]) begin
                fall_c[d]++;
                raw[d] = {raw[d][30:0], act[d][2]};
            end
            if (!prev_sck[d] && act[d][3]) rise_c[d]++;
            if (act[d][4]) begin
                hi_run[d]++;
            end else begin
                if (seen_lo[d] && hi_run[d] > 0) begin
                    if (hi_run[d] < gmin[d]) gmin[d] = hi_run[d];
                    if (hi_run[d] > gmax[d]) gmax[d] = hi_run[d];
                end
                hi_run[d]  = 0;
                seen_lo[d] = 1'b1;
            end
            prev_sck[d] = act[d][3];
        end
    end

    task automatic send(input int d, input logic [31:0] w);
        @(negedge clk); #1;
        data_v[d]  = w;
        start_v[d] = 1'b1;
        @(negedge clk); #1;
        start_v[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int n, input int maxc, input string nm);
        for (int i = 0; i < maxc; i++) begin
            if (done_c[d] >= n) return;
            @(negedge clk); #1;
        end
        if (done_c[d] < n) begin
            checks++;
            failures++;
            $display("FAIL %s timeout actual_done=%0d required_done=%0d", nm, done_c[d], n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        for (int d = 0; d < 3; d++) begin
            rst[d]     = 1'b0;
            start_v[d] = 1'b0;
            data_v[d]  = '0;
            clr(d);
        end
        #1;
        for (int d = 0; d < 3; d++) rst[d] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_d0", 32'(act[0]), 32'h10);
        chk("reset_d2", 32'(act[2]), 32'h10);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        repeat (2) @(negedge clk);

        // 0xA5, BITS=8 DIV=2.
        clr(0);
        send(0, 32'hA5);
        wait_done(0, 1, 200, "a5_done");
        repeat (3) @(negedge clk); #1;
        chk("a5_mosi_bits", raw[0], INV ? 32'h5A : 32'hA5);
        chk("a5_cs_low",    32'(csl_c[0]),  32'd36);
        chk("a5_done_cnt",  32'(done_c[0]), 32'd1);
        chk("a5_falls",     32'(fall_c[0]), 32'd8);
        chk("a5_rises",     32'(rise_c[0]), 32'd8);

        // 32-bit loopback, receiver stores !mosi.
        clr(2);
        send(2, 32'hDEADBEEF);
        wait_done(2, 1, 400, "loop_done");
        repeat (3) @(negedge clk); #1;
        chk("loop_word",   ~raw[2], INV ? 32'hDEADBEEF : 32'h21524110);
        chk("loop_cs_low", 32'(csl_c[2]),  32'd198);
        chk("loop_falls",  32'(fall_c[2]), 32'd32);

        // start hammered with changing data during a transaction.
        clr(0);
        @(negedge clk); #1;
        data_v[0]  = 32'h3C;
        start_v[0] = 1'b1;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk); #1;
            data_v[0]  = $urandom;
            start_v[0] = 1'b1;
        end
        @(negedge clk); #1;
        start_v[0] = 1'b0;
        wait_done(0, 1, 50, "ign_done");
        repeat (6) @(negedge clk); #1;
        chk("ign_word",     raw[0],          INV ? 32'hC3 : 32'h3C);
        chk("ign_done_cnt", 32'(done_c[0]),  32'd1);
        chk("ign_cs_low",   32'(csl_c[0]),   32'd36);

        // Reset at the 5th sck falling edge, then a clean 0x0F.
        clr(0);
        send(0, 32'h96);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk); #1;
            if (fall_c[0] >= 5) hit = 1'b1;
        end
        chk("abort_reached_fall5", 32'(hit), 32'd1);
        chk("abort_mid_cs", 32'(act[0][4]), 32'd0);
        rst[0] = 1'b1;
        #1;
        chk("abort_async", 32'(act[0]), 32'h10);
        repeat (3) @(negedge clk); #1;
        rst[0] = 1'b0;
        repeat (4) @(negedge clk); #1;
        chk("abort_no_done", 32'(done_c[0]), 32'd0);
        clr(0);
        send(0, 32'h0F);
        wait_done(0, 1, 200, "post_rst_done");
        repeat (3) @(negedge clk); #1;
        chk("post_rst_word",   raw[0],        INV ? 32'hF0 : 32'h0F);
        chk("post_rst_cs_low", 32'(csl_c[0]), 32'd36);

        // start held high, DIV=1: back-to-back words.
        clr(1);
        @(negedge clk); #1;
        data_v[1]  = 32'h81;
        start_v[1] = 1'b1;
        wait_done(1, 3, 100, "b2b_done");
        start_v[1] = 1'b0;
        repeat (25) @(negedge clk); #1;
        chk("b2b_done_cnt", 32'(done_c[1]), 32'd3);
        chk("b2b_gap_min",  32'(gmin[1]),   32'd1);
        chk("b2b_gap_max",  32'(gmax[1]),   32'd1);
        chk("b2b_cs_low",   32'(csl_c[1]),  32'd54);
        chk("b2b_word",     raw[1],         INV ? 32'h7E7E7E : 32'h818181);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
